// File: rtl/ps2_key_tracker_if.sv
// Scan-code byte stream between ps2_keyboard (master) and ps2_key_tracker (slave).
// The slave pops a byte on any clock edge where kbd_valid && kbd_ready.
interface ps2_key_tracker_if;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic       kbd_ready;

  modport master (
    output kbd_data,
    output kbd_valid,
    input  kbd_ready
  );

  modport slave (
    input  kbd_data,
    input  kbd_valid,
    output kbd_ready
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 set-2 make/break sequences, tracks the held key,
// drops typematic auto-repeat, counts presses and maps the code to lowercase ASCII.
// Optional feature: define PS2_EXT_CODE_EN to decode E0-prefixed (extended) keys;
// without it 0xE0 bytes are discarded and key_ext is tied low.
module ps2_key_tracker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  ps2_key_tracker_if.slave kbd,
  output logic [7:0]       key_code,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic             key_ext,
  output logic [CNT_W-1:0] press_count,
  output logic             code_valid
);

`ifdef PS2_EXT_CODE_EN
  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;
`else
  typedef enum logic [1:0] {IDLE, BREAK} state_t;
`endif

  state_t     state, next_state;
  logic       consume;
  logic [7:0] rx_byte;
  logic       do_make;
  logic       make_ext;
  logic       do_break;
  logic       is_repeat;
  logic       new_press;

  // Lowercase ASCII for the set-2 codes we display; everything else reads as 0x00.
  function automatic logic [7:0] ascii_lut(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  assign consume = kbd.kbd_valid && kbd.kbd_ready;
  assign rx_byte = kbd.kbd_data;

  // Ready comes up on the first edge after reset and then stays high: no backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) kbd.kbd_ready <= 1'b0;
    else     kbd.kbd_ready <= 1'b1;
  end

  // Sequence state register; it only moves on edges that pop a byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Classify the popped byte as prefix, make or break and pick the next state.
  always_comb begin
    next_state = state;
    do_make    = 1'b0;
    make_ext   = 1'b0;
    do_break   = 1'b0;
    if (consume) begin
      case (state)
        IDLE: begin
          if (rx_byte == 8'hF0) begin
            next_state = BREAK;
          end else if (rx_byte == 8'hE0) begin
`ifdef PS2_EXT_CODE_EN
            next_state = EXT;
`else
            next_state = IDLE;
`endif
          end else begin
            do_make = 1'b1;
          end
        end
        BREAK: begin
          do_break   = (rx_byte == key_code) && !key_ext;
          next_state = IDLE;
        end
`ifdef PS2_EXT_CODE_EN
        EXT: begin
          if (rx_byte == 8'hF0) begin
            next_state = EXT_BREAK;
          end else begin
            do_make    = 1'b1;
            make_ext   = 1'b1;
            next_state = IDLE;
          end
        end
        EXT_BREAK: begin
          do_break   = (rx_byte == key_code) && key_ext;
          next_state = IDLE;
        end
`endif
        default: next_state = IDLE;
      endcase
    end
  end

  // A make of the key already held (same code, same prefix) is typematic repeat.
  assign is_repeat = key_down && (rx_byte == key_code) && (key_ext == make_ext);
  assign new_press = do_make && !is_repeat;

  // Key registers, press counter and the one-cycle new-press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code    <= 8'h00;
      key_ascii   <= 8'h00;
      key_down    <= 1'b0;
      press_count <= '0;
      code_valid  <= 1'b0;
    end else begin
      code_valid <= new_press;
      if (new_press) begin
        key_code    <= rx_byte;
        key_ascii   <= make_ext ? 8'h00 : ascii_lut(rx_byte);
        key_down    <= 1'b1;
        press_count <= press_count + CNT_W'(1);
      end else if (do_break) begin
        key_down <= 1'b0;
      end
    end
  end

`ifdef PS2_EXT_CODE_EN
  // Extended flag travels with key_code on every new press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            key_ext <= 1'b0;
    else if (new_press) key_ext <= make_ext;
  end
`else
  assign key_ext = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Testbench for ps2_key_tracker: directed scenarios plus a randomized byte stream
// checked against a sequence-level reference model. Honours PS2_EXT_CODE_EN.
module tb_ps2_key_tracker;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       key_code, key_ascii;
  logic             key_down, key_ext, code_valid;
  logic [CNT_W-1:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  logic consumed;

  logic [7:0] lut [256];

  // Reference model: last made key plus pending break / extended prefix flags.
  logic [7:0]       m_code, m_ascii;
  logic             m_down, m_ext, m_pulse;
  logic [CNT_W-1:0] m_count;
  logic             m_brk, m_extp;

  always #5 clk = ~clk;

  ps2_key_tracker_if kbd_bus();

  ps2_key_tracker #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .kbd         (kbd_bus.slave),
    .key_code    (key_code),
    .key_ascii   (key_ascii),
    .key_down    (key_down),
    .key_ext     (key_ext),
    .press_count (press_count),
    .code_valid  (code_valid)
  );

  task automatic init_lut();
    string letters;
    logic [7:0] lcodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dcodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    letters = "abcdefghijklmnopqrstuvwxyz";
    for (int i = 0; i < 256; i++) lut[i] = 8'h00;
    for (int i = 0; i < 26; i++) lut[lcodes[i]] = letters[i];
    for (int i = 0; i < 10; i++) lut[dcodes[i]] = 8'h30 + 8'(i);
    lut[8'h29] = 8'h20;
    lut[8'h5A] = 8'h0D;
  endtask

  task automatic model_reset();
    m_code = 8'h00; m_ascii = 8'h00; m_down = 1'b0; m_ext = 1'b0;
    m_count = '0; m_pulse = 1'b0; m_brk = 1'b0; m_extp = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_pulse = 1'b0;
    if (m_brk) begin
      if (b == m_code && m_ext == m_extp) m_down = 1'b0;
      m_brk = 1'b0;
      m_extp = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0 && !m_extp) begin
`ifdef PS2_EXT_CODE_EN
      m_extp = 1'b1;
`endif
    end else begin
      if (!(m_down && b == m_code && m_ext == m_extp)) begin
        m_code  = b;
        m_ext   = m_extp;
        m_ascii = m_extp ? 8'h00 : lut[b];
        m_down  = 1'b1;
        m_count = m_count + 1'b1;
        m_pulse = 1'b1;
      end
      m_extp = 1'b0;
    end
  endtask

  // Called at a negedge; presents one byte for one edge and returns at the next negedge.
  task automatic send_byte(input logic [7:0] b);
    kbd_bus.kbd_data  = b;
    kbd_bus.kbd_valid = 1'b1;
    consumed = kbd_bus.kbd_ready;
    @(posedge clk);
    @(negedge clk);
    if (consumed) model_byte(b);
    else          m_pulse = 1'b0;
    if (code_valid) pulse_cnt++;
  endtask

  task automatic idle_cycle();
    kbd_bus.kbd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_pulse = 1'b0;
    if (code_valid) pulse_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    kbd_bus.kbd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle_cycle();
    pulse_cnt = 0;
  endtask

  task automatic test_reset();
    kbd_bus.kbd_valid = 1'b0;
    kbd_bus.kbd_data  = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({key_code, key_ascii, key_down, key_ext, press_count, code_valid} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got code=%h ascii=%h down=%b ext=%b cnt=%0d cv=%b, want all 0",
               key_code, key_ascii, key_down, key_ext, press_count, code_valid);
    end
    n_checks++;
    if (kbd_bus.kbd_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got %b want 0", kbd_bus.kbd_ready);
    end
    rst = 1'b0;
    model_reset();
    idle_cycle();
    n_checks++;
    if (kbd_bus.kbd_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ready_after_reset: got %b want 1", kbd_bus.kbd_ready);
    end
  endtask

  task automatic test_make_break();
    do_reset();
    send_byte(8'h1C);
    n_checks++;
    if ({key_code, key_ascii, key_down, press_count, code_valid} !== {8'h1C, 8'h61, 1'b1, 8'd1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL make_1c: got code=%h ascii=%h down=%b cnt=%0d cv=%b, want 1c 61 1 1 1",
               key_code, key_ascii, key_down, press_count, code_valid);
    end
    send_byte(8'hF0);
    n_checks++;
    if (code_valid !== 1'b0 || key_down !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pulse_width: got cv=%b down=%b, want cv=0 down=1", code_valid, key_down);
    end
    send_byte(8'h1C);
    n_checks++;
    if ({key_down, press_count, code_valid} !== {1'b0, 8'd1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL break_1c: got down=%b cnt=%0d cv=%b, want 0 1 0", key_down, press_count, code_valid);
    end
  endtask

  task automatic test_auto_repeat();
    do_reset();
    repeat (4) send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    n_checks++;
    if (press_count !== 8'd1 || pulse_cnt != 1 || key_down !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL auto_repeat: got cnt=%0d pulses=%0d down=%b, want 1 1 0", press_count, pulse_cnt, key_down);
    end
  endtask

  task automatic test_replace();
    do_reset();
    send_byte(8'h16);
    send_byte(8'h1E);
    send_byte(8'hF0);
    send_byte(8'h16);
    n_checks++;
    if ({key_code, key_ascii, key_down, press_count} !== {8'h1E, 8'h32, 1'b1, 8'd2}) begin
      n_fail++;
      $display("[TB] FAIL replace: got code=%h ascii=%h down=%b cnt=%0d, want 1e 32 1 2",
               key_code, key_ascii, key_down, press_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h29);
      send_byte(8'hF0);
      send_byte(8'h29);
      if (i == 254) begin
        n_checks++;
        if (press_count !== 8'd255) begin
          n_fail++;
          $display("[TB] FAIL count_max: got %0d want 255", press_count);
        end
      end
    end
    n_checks++;
    if ({press_count, key_ascii, key_down} !== {8'd0, 8'h20, 1'b0} || pulse_cnt != 256) begin
      n_fail++;
      $display("[TB] FAIL wrap: got cnt=%0d ascii=%h down=%b pulses=%0d, want 0 20 0 256",
               press_count, key_ascii, key_down, pulse_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int tries;
    do_reset();
    send_byte(8'hF0);
    kbd_bus.kbd_data = 8'h1C;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if ({key_code, key_ascii, key_down, key_ext, press_count, code_valid, kbd_bus.kbd_ready} !== '0) begin
        n_fail++;
        $display("[TB] FAIL mid_reset_%0d: got code=%h down=%b cnt=%0d cv=%b ready=%b, want all 0",
                 c, key_code, key_down, press_count, code_valid, kbd_bus.kbd_ready);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    model_reset();
    consumed = 1'b0;
    tries = 0;
    while (!consumed && tries < 4) begin
      send_byte(8'h1C);
      tries++;
    end
    n_checks++;
    if (!consumed) begin
      n_fail++;
      $display("[TB] FAIL post_reset_consume: byte not consumed within %0d cycles", tries);
    end else if ({key_code, key_down, press_count, code_valid} !== {8'h1C, 1'b1, 8'd1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL post_reset_make: got code=%h down=%b cnt=%0d cv=%b, want 1c 1 1 1",
               key_code, key_down, press_count, code_valid);
    end
  endtask

`ifdef PS2_EXT_CODE_EN
  task automatic test_ext();
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h75);
    n_checks++;
    if ({key_ext, key_code, key_ascii, key_down, code_valid} !== {1'b1, 8'h75, 8'h00, 1'b1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL ext_make: got ext=%b code=%h ascii=%h down=%b cv=%b, want 1 75 00 1 1",
               key_ext, key_code, key_ascii, key_down, code_valid);
    end
    send_byte(8'hF0);
    send_byte(8'h75);
    n_checks++;
    if (key_down !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ext_plain_break: got down=%b want 1", key_down);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    n_checks++;
    if (key_down !== 1'b0 || press_count !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL ext_break: got down=%b cnt=%0d want 0 1", key_down, press_count);
    end
  endtask
`else
  task automatic test_ext();
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h1C);
    n_checks++;
    if ({key_ext, key_code, key_ascii, key_down, press_count} !== {1'b0, 8'h1C, 8'h61, 1'b1, 8'd1}) begin
      n_fail++;
      $display("[TB] FAIL e0_dropped: got ext=%b code=%h ascii=%h down=%b cnt=%0d, want 0 1c 61 1 1",
               key_ext, key_code, key_ascii, key_down, press_count);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0] keys [6] = '{8'h1C, 8'h32, 8'h16, 8'h29, 8'h5A, 8'h75};
    logic [7:0] b;
    int r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       b = 8'hF0;
      else if (r == 2) b = 8'hE0;
      else if (r == 3) b = 8'($urandom_range(0, 255));
      else             b = keys[$urandom_range(0, 5)];
      if ($urandom_range(0, 15) == 0) idle_cycle();
      send_byte(b);
      n_checks++;
      if ({key_code, key_ascii, key_down, key_ext, press_count, code_valid, consumed} !==
          {m_code, m_ascii, m_down, m_ext, m_count, m_pulse, 1'b1}) begin
        n_fail++;
        $display("[TB] FAIL random_%0d byte=%h: got code=%h ascii=%h down=%b ext=%b cnt=%0d cv=%b acc=%b, want %h %h %b %b %0d %b 1",
                 i, b, key_code, key_ascii, key_down, key_ext, press_count, code_valid, consumed,
                 m_code, m_ascii, m_down, m_ext, m_count, m_pulse);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    init_lut();
    model_reset();
    test_reset();
    test_make_break();
    test_auto_repeat();
    test_replace();
    test_wrap();
    test_reset_mid();
    test_ext();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
